// File: rtl/serial_sbox_layer_if.sv
// Handshake and S-box bus bundle for serial_sbox_layer.
interface serial_sbox_layer_if #(
    parameter int unsigned LANES = 8
);
    localparam int unsigned LW = 6;
    localparam int unsigned DW = LW * LANES;

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [LW-1:0] sb_x;
    logic [LW-1:0] sb_y;

    // Round logic and the external S-box sit on the master side.
    modport master (
        output in_valid, in_data, out_ready, sb_y,
        input  in_ready, out_valid, out_data, sb_x
    );

    // The sequencer itself.
    modport slave (
        input  in_valid, in_data, out_ready, sb_y,
        output in_ready, out_valid, out_data, sb_x
    );
endinterface

// File: rtl/serial_sbox_layer.sv
// Serial substitution layer: one shared 6-bit S-box applied lane by lane.
module serial_sbox_layer #(
    parameter int unsigned LANES = 8,
    parameter int unsigned CW    = 5
) (
    input  logic                clk,
    input  logic                rst,
    serial_sbox_layer_if.slave  bus,
    output logic                busy
);
    localparam int unsigned LW = 6;
    localparam int unsigned IW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CW-1:0] LAST = CW'(LANES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [LANES-1:0][LW-1:0] word_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    word_t         src_q, src_d;
    word_t         res_q, res_d;

    // State, counter and word registers; reset discards any word in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            src_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            res_q   <= res_d;
        end
    end

    // Next-state logic; sb_y is only captured in RUN so X elsewhere never lands.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        res_d   = res_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    src_d   = word_t'(bus.in_data);
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d[cnt_q[IW-1:0]] = bus.sb_y;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode the state register and are forced low while rst is held.
    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = (state_q == DONE) && !rst;
    assign busy          = (state_q == RUN)  && !rst;
    assign bus.out_data  = rst ? '0 : res_q;
    assign bus.sb_x      = busy ? src_q[cnt_q[IW-1:0]] : '0;

endmodule

// File: tb/tb_serial_sbox_layer.sv
// Directed, table-driven bench for serial_sbox_layer.
module tb_serial_sbox_layer;
    localparam int unsigned LANES = 8;
    localparam int unsigned CW    = 5;

    typedef logic [LANES-1:0][5:0] lanes_t;
    typedef struct {
        lanes_t data;
        lanes_t exp;
        string  name;
    } vec_t;

    logic clk;
    logic rst;
    logic busy;
    logic use_real;
    int   checks;
    int   passed;

    serial_sbox_layer_if #(.LANES(LANES)) bus ();

    serial_sbox_layer #(.LANES(LANES), .CW(CW)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // GF(2^6) multiply, modulus x^6 + x + 1.
    function automatic logic [5:0] gf_mul(input logic [5:0] a, input logic [5:0] b);
        logic [5:0] p;
        logic [5:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 6; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[5] ? ({aa[4:0], 1'b0} ^ 6'h03) : {aa[4:0], 1'b0};
        end
        return p;
    endfunction

    // Power-map S-box model (cube) standing in for the real instance; fixes zero.
    function automatic logic [5:0] power_map(input logic [5:0] x);
        return gf_mul(gf_mul(x, x), x);
    endfunction

    // External S-box: complement stub or power map.
    assign bus.sb_y = use_real ? power_map(bus.sb_x) : (bus.sb_x ^ 6'h3F);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for in_ready; an expired bound shows as a failed check.
    task automatic wait_ready(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.in_ready) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        chk({tag, " in_ready wait"}, 64'(seen), 64'(1));
    endtask

    // Push one word, follow the lane sweep, hold backpressure, then hand it off.
    task automatic run_word(input lanes_t data, input lanes_t exp, input int hold, input string tag);
        bus.in_data   = data;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        wait_ready(tag);
        step();
        bus.in_valid = 1'b0;
        bus.in_data  = ~data;
        for (int k = 0; k < int'(LANES); k++) begin
            chk({tag, " sb_x lane"}, 64'(bus.sb_x), 64'(data[k[2:0]]));
            chk({tag, " out_valid low in RUN"}, 64'(bus.out_valid), 64'(0));
            if (k == 0) begin
                chk({tag, " busy in RUN"}, 64'(busy), 64'(1));
                chk({tag, " in_ready in RUN"}, 64'(bus.in_ready), 64'(0));
            end
            step();
        end
        chk({tag, " out_valid"}, 64'(bus.out_valid), 64'(1));
        chk({tag, " out_data"}, 64'(bus.out_data), 64'(exp));
        chk({tag, " busy in DONE"}, 64'(busy), 64'(0));
        chk({tag, " sb_x in DONE"}, 64'(bus.sb_x), 64'(0));
        for (int h = 0; h < hold; h++) begin
            bus.in_valid = ~h[0];
            step();
            chk({tag, " held out_valid"}, 64'(bus.out_valid), 64'(1));
            chk({tag, " held out_data"}, 64'(bus.out_data), 64'(exp));
            chk({tag, " held in_ready"}, 64'(bus.in_ready), 64'(0));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk({tag, " out_valid after handshake"}, 64'(bus.out_valid), 64'(0));
        chk({tag, " in_ready after handshake"}, 64'(bus.in_ready), 64'(1));
    endtask

    vec_t   vecs[5];
    lanes_t ramp;
    lanes_t ramp_exp;
    lanes_t w15;
    lanes_t w2a;
    logic   seen_valid;

    initial begin
        checks        = 0;
        passed        = 0;
        use_real      = 1'b0;
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 48'hA5A5_5A5A_F0F0;
        bus.out_ready = 1'b0;

        ramp     = {6'd7, 6'd6, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1, 6'd0};
        ramp_exp = {6'd56, 6'd57, 6'd58, 6'd59, 6'd60, 6'd61, 6'd62, 6'd63};
        w15      = {8{6'h15}};
        w2a      = {8{6'h2A}};
        vecs[0] = '{data: ramp, exp: ramp_exp, name: "ramp"};
        vecs[1] = '{data: w15, exp: w2a, name: "all15"};
        vecs[2] = '{data: w2a, exp: w15, name: "all2a"};
        vecs[3] = '{data: {8{6'h00}}, exp: {8{6'h3F}}, name: "zeros"};
        vecs[4] = '{data: {6'h05, 6'h3E, 6'h2F, 6'h10, 6'h20, 6'h01, 6'h00, 6'h3F},
                    exp:  {6'h3A, 6'h01, 6'h10, 6'h2F, 6'h1F, 6'h3E, 6'h3F, 6'h00},
                    name: "mixed"};

        // Reset held for two edges with in_valid asserted.
        #1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("reset in_ready", 64'(bus.in_ready), 64'(0));
            chk("reset out_valid", 64'(bus.out_valid), 64'(0));
            chk("reset out_data", 64'(bus.out_data), 64'(0));
            chk("reset sb_x", 64'(bus.sb_x), 64'(0));
            chk("reset busy", 64'(busy), 64'(0));
        end
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("post-reset in_ready", 64'(bus.in_ready), 64'(1));
        chk("post-reset busy", 64'(busy), 64'(0));

        // Table of single words with the complement stub.
        for (int v = 0; v < 5; v++) begin
            run_word(vecs[v].data, vecs[v].exp, 0, vecs[v].name);
        end

        // Backpressure: five stalled cycles with in_valid pulsing.
        run_word(ramp, ramp_exp, 5, "backpressure");
        chk("idle busy after backpressure", 64'(busy), 64'(0));

        // Back-to-back with in_valid and out_ready held high.
        bus.out_ready = 1'b1;
        bus.in_data   = w15;
        bus.in_valid  = 1'b1;
        wait_ready("b2b first");
        step();
        bus.in_data = w2a;
        for (int k = 0; k < int'(LANES); k++) begin
            chk("b2b first sb_x", 64'(bus.sb_x), 64'(6'h15));
            step();
        end
        chk("b2b first out_valid", 64'(bus.out_valid), 64'(1));
        chk("b2b first out_data", 64'(bus.out_data), 64'(w2a));
        step();
        chk("b2b idle in_ready", 64'(bus.in_ready), 64'(1));
        chk("b2b idle out_valid", 64'(bus.out_valid), 64'(0));
        step();
        bus.in_valid = 1'b0;
        chk("b2b second accepted busy", 64'(busy), 64'(1));
        chk("b2b second sb_x lane0", 64'(bus.sb_x), 64'(6'h2A));
        for (int k = 0; k < int'(LANES); k++) begin
            step();
        end
        chk("b2b second out_valid", 64'(bus.out_valid), 64'(1));
        chk("b2b second out_data", 64'(bus.out_data), 64'(w15));
        step();
        bus.out_ready = 1'b0;
        chk("b2b second handshake", 64'(bus.out_valid), 64'(0));

        // Reset while cnt == 3.
        bus.in_data  = ramp;
        bus.in_valid = 1'b1;
        wait_ready("midreset");
        step();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
        end
        chk("midreset sb_x at cnt3", 64'(bus.sb_x), 64'(3));
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("midreset in_ready", 64'(bus.in_ready), 64'(1));
        chk("midreset busy", 64'(busy), 64'(0));
        chk("midreset sb_x", 64'(bus.sb_x), 64'(0));
        chk("midreset out_data", 64'(bus.out_data), 64'(0));
        bus.out_ready = 1'b1;
        seen_valid    = 1'b0;
        for (int i = 0; i < 12; i++) begin
            seen_valid = seen_valid | bus.out_valid;
            step();
        end
        bus.out_ready = 1'b0;
        chk("midreset no emission", 64'(seen_valid), 64'(0));
        run_word(vecs[4].data, vecs[4].exp, 0, "after midreset");

        // Power-map S-box on an all-zero word.
        use_real = 1'b1;
        run_word({8{6'h00}}, {8{6'h00}}, 0, "powermap zero");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end
endmodule
